riscv_hazard_ctrl: RTL and testbench
====================================

# riscv_hazard_ctrl

Pipeline hazard controller for the five-stage RISC-V core. It sits beside the forwarding unit and handles the hazards forwarding cannot resolve:
- load-use dependencies between ID and EX
- taken branches and jumps resolved in EX
- multi-cycle multiply/divide operations in EX, through a start/done handshake with the M-extension unit

It drives the stall and flush controls of the PC and the pipeline registers, and keeps saturating stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- rs1_D  input  5  source register 1 of instruction in ID
- rs2_D  input  5  source register 2 of instruction in ID
- rs1_used_D  input  1  ID instruction reads rs1
- rs2_used_D  input  1  ID instruction reads rs2
- rd_E  input  5  destination register of instruction in EX
- MemRead_E  input  1  EX instruction is a load
- PCSrc_E  input  1  EX instruction is a taken branch or jump
- md_op_E  input  1  EX instruction is MUL/DIV/REM
- md_done  input  1  M-unit result valid; one-cycle pulse
- Stall_F  output  1  hold PC
- Stall_D  output  1  hold IF/ID
- Stall_E  output  1  hold ID/EX
- Flush_D  output  1  clear IF/ID to NOP
- Flush_E  output  1  clear ID/EX to NOP
- Bubble_M  output  1  load NOP into EX/MEM
- md_start  output  1  one-cycle start pulse to M-unit
- md_busy  output  1  FSM in MD_WAIT
- stall_cnt  output  CNT_W  cycles with Stall_D=1, saturating
- flush_cnt  output  CNT_W  taken-branch flush events, saturating

## Operation
- Reset (async, rst_n=0):
  - state=IDLE; stall_cnt=0; flush_cnt=0.
  - All control outputs evaluate to 0, given that md_op_E, MemRead_E and PCSrc_E are 0 in reset.
- FSM states: IDLE, MD_WAIT.
- IDLE -> MD_WAIT when md_op_E=1. MD_WAIT -> IDLE when md_done=1. md_done is ignored in IDLE.
- Control outputs are combinational from state and inputs.
- Load-use:
  - lu = MemRead_E & (rd_E!=0) & ((rs1_used_D & rs1_D==rd_E) | (rs2_used_D & rs2_D==rd_E)).
  - In IDLE with lu=1 and PCSrc_E=0: Stall_F=Stall_D=1, Flush_E=1.
- Branch (IDLE, PCSrc_E=1): Flush_D=Flush_E=1, no stalls. Overrides lu.
- Multiply/divide:
  - md_start = (state==IDLE) & md_op_E.
  - Stall_F=Stall_D=Stall_E=Bubble_M=1 when (IDLE & md_op_E) or (MD_WAIT & !md_done).
  - On the md_done cycle all stalls drop and EX/MEM captures the result.
- Input exclusivity: md_op_E, MemRead_E and PCSrc_E are mutually exclusive; this is guaranteed by the decoder.
- In MD_WAIT:
  - PCSrc_E and lu are not acted on. The EX instruction is the M-op and the ID instruction is held.
  - lu is re-evaluated after release.
- md_busy = (state==MD_WAIT).
- Counters:
  - stall_cnt increments on every cycle with Stall_D=1.
  - flush_cnt increments on every cycle with PCSrc_E=1 in IDLE.
  - Both hold at 2^CNT_W-1 and never wrap.

## Timing
- Load-use costs exactly 1 bubble: the stall is seen in one cycle, and on the next cycle the load is in MEM, so lu=0.
- Branch flush is the same cycle as PCSrc_E. The penalty is 2 instructions.
- M-op: md_start is in cycle T0. If md_done arrives at cycle T0+N (N≥1), the stall lasts cycles T0..T0+N-1, i.e. N stall cycles, and stall_cnt grows by N.
- An M-op immediately following another M-op: the second reaches EX on the cycle after release and starts a new sequence with a fresh md_start.
- Reset asserted mid-MD_WAIT: immediate return to IDLE and counters cleared. The M-unit is reset by the same rst_n.

## Test plan
- Load x5 in EX (rd_E=5, MemRead_E=1), ADD reading rs2_D=5 in ID -> one cycle with Stall_F=Stall_D=Flush_E=1; stall_cnt 0->1.
- Same as above with rd_E=0 -> no stall, stall_cnt unchanged.
- PCSrc_E=1 with a simultaneous load-use match -> Flush_D=Flush_E=1, Stall_F=0; flush_cnt +1.
- md_op_E=1 with md_done 4 cycles later -> md_start for exactly 1 cycle; Stall_E=Bubble_M=1 for 4 cycles; md_busy for cycles T0+1..T0+4; stall_cnt +4.
- md_done pulsed while in IDLE -> no state change and no outputs.
- CNT_W=4, continuous load-use for 20 events -> stall_cnt saturates at 15. Then rst_n low mid-MD_WAIT -> state IDLE, counters 0, all outputs 0.

Source files
------------

// File: rtl/riscv_hazard_ctrl_if.sv
// riscv_hazard_ctrl_if: ID/EX hazard inputs, M-unit handshake and pipeline stall/flush controls.
interface riscv_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] rs1_D, rs2_D, rd_E;
  logic rs1_used_D, rs2_used_D, MemRead_E, PCSrc_E, md_op_E, md_done;
  logic Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Bubble_M, md_start, md_busy;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output rs1_D, rs2_D, rd_E, rs1_used_D, rs2_used_D, MemRead_E, PCSrc_E, md_op_E, md_done,
    input Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Bubble_M, md_start, md_busy, stall_cnt, flush_cnt
  );
  modport slave (
    input rs1_D, rs2_D, rd_E, rs1_used_D, rs2_used_D, MemRead_E, PCSrc_E, md_op_E, md_done,
    output Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Bubble_M, md_start, md_busy, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl: load-use, taken-branch and multi-cycle M-op hazard control
// with saturating stall/flush performance counters.
module riscv_hazard_ctrl #(parameter int CNT_W = 16) (
  input logic clk,
  input logic rst_n,
  riscv_hazard_ctrl_if.slave hz
);
  typedef enum logic {IDLE, MD_WAIT} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic idle, lu, br, md_stall, lu_stall;
  always_comb begin
    idle = state_q == IDLE;
    lu = hz.MemRead_E && hz.rd_E != 5'd0 &&
         ((hz.rs1_used_D && hz.rs1_D == hz.rd_E) || (hz.rs2_used_D && hz.rs2_D == hz.rd_E));
    br = idle && hz.PCSrc_E;
    // the M-op stall drops on the md_done cycle so EX/MEM captures the result
    md_stall = idle ? hz.md_op_E : !hz.md_done;
    lu_stall = idle && lu && !hz.PCSrc_E;
    state_d = idle ? (hz.md_op_E ? MD_WAIT : IDLE) : (hz.md_done ? IDLE : MD_WAIT);
    hz.Stall_F = md_stall || lu_stall;
    hz.Stall_D = md_stall || lu_stall;
    hz.Stall_E = md_stall;
    hz.Bubble_M = md_stall;
    hz.Flush_D = br;
    hz.Flush_E = br || lu_stall;
    hz.md_start = idle && hz.md_op_E;
    hz.md_busy = !idle;
    stall_cnt_d = stall_cnt_q + CNT_W'((md_stall || lu_stall) && !(&stall_cnt_q));
    flush_cnt_d = flush_cnt_q + CNT_W'(br && !(&flush_cnt_q));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb_riscv_hazard_ctrl: directed checks of load-use, branch, M-op handshake,
// counter saturation and async reset, with CNT_W=4.
module tb_riscv_hazard_ctrl;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  riscv_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
  riscv_hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  always #5 clk = ~clk;
  // {Stall_F, Stall_D, Stall_E, Flush_D, Flush_E, Bubble_M, md_start, md_busy}
  logic [7:0] ctrl;
  assign ctrl = {hz.Stall_F, hz.Stall_D, hz.Stall_E, hz.Flush_D, hz.Flush_E, hz.Bubble_M, hz.md_start, hz.md_busy};
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    hz.rs1_D = 5'd0; hz.rs2_D = 5'd0; hz.rd_E = 5'd0;
    hz.rs1_used_D = 1'b0; hz.rs2_used_D = 1'b0; hz.MemRead_E = 1'b0;
    hz.PCSrc_E = 1'b0; hz.md_op_E = 1'b0; hz.md_done = 1'b0;
  endtask
  initial begin
    clr();
    #12;
    check("rst_ctrl", ctrl, 8'b0000_0000);
    check("rst_scnt", 8'(hz.stall_cnt), 8'd0);
    check("rst_fcnt", 8'(hz.flush_cnt), 8'd0);
    rst_n = 1'b1;
    cyc();
    // load x5 in EX, ADD reads x5 via rs2
    hz.rd_E = 5'd5; hz.MemRead_E = 1'b1; hz.rs2_D = 5'd5; hz.rs2_used_D = 1'b1;
    #1 check("lu_rs2", ctrl, 8'b1100_1000);
    cyc();
    check("lu_scnt", 8'(hz.stall_cnt), 8'd1);
    hz.MemRead_E = 1'b0;
    #1 check("lu_release", ctrl, 8'b0000_0000);
    // x0 destination never stalls
    hz.rd_E = 5'd0; hz.rs2_D = 5'd0; hz.MemRead_E = 1'b1;
    #1 check("lu_x0", ctrl, 8'b0000_0000);
    cyc();
    check("lu_x0_scnt", 8'(hz.stall_cnt), 8'd1);
    // rs1 match but rs1 not used
    clr(); hz.rd_E = 5'd7; hz.MemRead_E = 1'b1; hz.rs1_D = 5'd7;
    #1 check("lu_rs1_unused", ctrl, 8'b0000_0000);
    hz.rs1_used_D = 1'b1;
    #1 check("lu_rs1", ctrl, 8'b1100_1000);
    cyc();
    check("lu_rs1_scnt", 8'(hz.stall_cnt), 8'd2);
    // taken branch overrides a load-use match
    hz.PCSrc_E = 1'b1;
    #1 check("br_lu", ctrl, 8'b0001_1000);
    cyc();
    check("br_fcnt", 8'(hz.flush_cnt), 8'd1);
    check("br_scnt", 8'(hz.stall_cnt), 8'd2);
    // M-op with md_done 4 cycles after md_start; next M-op follows immediately
    clr(); hz.md_op_E = 1'b1;
    #1 check("md_t0", ctrl, 8'b1110_0110);
    cyc(); check("md_t1", ctrl, 8'b1110_0101);
    cyc(); check("md_t2", ctrl, 8'b1110_0101);
    cyc(); check("md_t3", ctrl, 8'b1110_0101);
    cyc(); hz.md_done = 1'b1;
    #1 check("md_t4_done", ctrl, 8'b0000_0001);
    cyc(); hz.md_done = 1'b0;
    check("md_scnt", 8'(hz.stall_cnt), 8'd6);
    check("md2_t0", ctrl, 8'b1110_0110);
    cyc(); hz.md_done = 1'b1;
    #1 check("md2_done", ctrl, 8'b0000_0001);
    cyc(); clr();
    #1 check("md2_idle", ctrl, 8'b0000_0000);
    check("md2_scnt", 8'(hz.stall_cnt), 8'd7);
    // md_done in IDLE is ignored
    hz.md_done = 1'b1;
    #1 check("done_idle", ctrl, 8'b0000_0000);
    cyc(); hz.md_done = 1'b0;
    #1 check("done_idle_next", ctrl, 8'b0000_0000);
    check("done_idle_scnt", 8'(hz.stall_cnt), 8'd7);
    // continuous load-use: 7 + 8 reaches 15, further events hold there
    hz.rd_E = 5'd3; hz.MemRead_E = 1'b1; hz.rs1_D = 5'd3; hz.rs1_used_D = 1'b1;
    cyc(8); check("sat_reach", 8'(hz.stall_cnt), 8'd15);
    cyc(12); check("sat_hold", 8'(hz.stall_cnt), 8'd15);
    clr(); hz.PCSrc_E = 1'b1;
    cyc(13); check("fsat_14", 8'(hz.flush_cnt), 8'd14);
    cyc(7); check("fsat_hold", 8'(hz.flush_cnt), 8'd15);
    // async reset mid-MD_WAIT
    clr(); hz.md_op_E = 1'b1;
    cyc(2); check("pre_rst_busy", ctrl, 8'b1110_0101);
    #2 rst_n = 1'b0; clr();
    #1 check("arst_ctrl", ctrl, 8'b0000_0000);
    check("arst_scnt", 8'(hz.stall_cnt), 8'd0);
    check("arst_fcnt", 8'(hz.flush_cnt), 8'd0);
    cyc(); check("arst_hold", ctrl, 8'b0000_0000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
